// File: rtl/bus_mem_responder_pkg.sv
// Shared definitions for the bus memory responder: default geometry of the
// RAM window, statistics counter widths and the FSM state encoding.
package bus_mem_responder_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_MEM_DEPTH  = 256;
  localparam int DEF_BASE_ADDR  = 0;

  // Saturating statistics counter widths.
  localparam int RW_COUNT_W  = 16;
  localparam int ERR_COUNT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ACCESS   = 3'd1,
    ST_RESP     = 3'd2,
    ST_ERR      = 3'd3,
    ST_WAIT_REL = 3'd4
  } state_t;

endpackage

// File: rtl/bus_mem_responder_ram_array.sv
// Synchronous single-port RAM with registered read data.
// The array has no reset so its contents survive a responder reset.
// Ports:
//   clk    - clock
//   en     - access enable; read data register loads mem[addr] when high
//   we     - write enable (qualified by en)
//   addr   - word address
//   wdata  - write data
//   rdata  - registered read data (old contents on a write cycle)
module bus_mem_responder_ram_array #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 8,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/bus_mem_responder.sv
// Memory-side responder for the CPU system bus. Decodes the bus address into
// a local RAM window and performs one registered access per strobe assertion.
//
// Handshake: oe_i/we_i are level strobes. A strobe seen in IDLE at edge N is
// one request; ready_o (or err_o for a bad request) is a one-cycle pulse.
// ready_o is high from edge N+1 to N+2, err_o from edge N to N+1. A strobe
// still held after the response parks the FSM in WAIT_REL until both strobes
// are low, so a held strobe never starts a second access.
//
// Ports:
//   clk, reset    - clock, asynchronous active-high reset
//   addr_i        - bus address
//   wdata_i       - bus write data
//   oe_i, we_i    - read / write strobes
//   rdata_o       - read data, non-zero only during a read response
//   rdata_oe_o    - data bus drive enable, high only during a read response
//   ready_o       - completion pulse
//   err_o         - error pulse
//   rd_count_o    - completed reads (saturating)
//   wr_count_o    - completed writes (saturating)
//   err_count_o   - errored requests (saturating)
//   fsm_state     - current FSM state for debug
module bus_mem_responder
  import bus_mem_responder_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int MEM_DEPTH  = DEF_MEM_DEPTH,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(DEF_BASE_ADDR)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ADDR_WIDTH-1:0]  addr_i,
  input  logic [DATA_WIDTH-1:0]  wdata_i,
  input  logic                   oe_i,
  input  logic                   we_i,
  output logic [DATA_WIDTH-1:0]  rdata_o,
  output logic                   rdata_oe_o,
  output logic                   ready_o,
  output logic                   err_o,
  output logic [RW_COUNT_W-1:0]  rd_count_o,
  output logic [RW_COUNT_W-1:0]  wr_count_o,
  output logic [ERR_COUNT_W-1:0] err_count_o,
  output state_t                 fsm_state
);

  localparam int OFF_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH+1)'(MEM_DEPTH);

  state_t                state;
  logic                  is_wr;
  logic [OFF_W-1:0]      off_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] ram_rdata;

  logic                  req;
  logic                  req_err;
  logic [ADDR_WIDTH-1:0] rel;

  assign req = oe_i | we_i;
  assign rel = addr_i - BASE_ADDR;

  // The range check uses the full-width difference; only afterwards is the
  // offset truncated to the RAM index width.
  assign req_err = (oe_i & we_i)
                 | addr_i[ADDR_WIDTH-1]
                 | (addr_i < BASE_ADDR)
                 | ({1'b0, rel} >= DEPTH_EXT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      is_wr       <= 1'b0;
      off_q       <= '0;
      wdata_q     <= '0;
      ready_o     <= 1'b0;
      err_o       <= 1'b0;
      rdata_oe_o  <= 1'b0;
      rd_count_o  <= '0;
      wr_count_o  <= '0;
      err_count_o <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            if (req_err) begin
              state <= ST_ERR;
              err_o <= 1'b1;
              if (err_count_o != '1) err_count_o <= err_count_o + ERR_COUNT_W'(1);
            end else begin
              state   <= ST_ACCESS;
              is_wr   <= we_i;
              off_q   <= rel[OFF_W-1:0];
              wdata_q <= wdata_i;
            end
          end
        end
        ST_ACCESS: begin
          // RAM operation happens on this edge; response is visible next cycle.
          state      <= ST_RESP;
          ready_o    <= 1'b1;
          rdata_oe_o <= ~is_wr;
          if (is_wr) begin
            if (wr_count_o != '1) wr_count_o <= wr_count_o + RW_COUNT_W'(1);
          end else begin
            if (rd_count_o != '1) rd_count_o <= rd_count_o + RW_COUNT_W'(1);
          end
        end
        ST_RESP: begin
          ready_o    <= 1'b0;
          rdata_oe_o <= 1'b0;
          state      <= req ? ST_WAIT_REL : ST_IDLE;
        end
        ST_ERR: begin
          err_o <= 1'b0;
          state <= req ? ST_WAIT_REL : ST_IDLE;
        end
        ST_WAIT_REL: begin
          if (!req) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Enable derives from the asynchronously reset state, so a reset during
  // ACCESS suppresses the pending write.
  bus_mem_responder_ram_array #(
    .DEPTH (MEM_DEPTH),
    .WIDTH (DATA_WIDTH),
    .AW    (OFF_W)
  ) u_ram_array (
    .clk   (clk),
    .en    (state == ST_ACCESS),
    .we    ((state == ST_ACCESS) && is_wr),
    .addr  (off_q),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  // Gating by the drive enable keeps rdata_o at zero outside a read response.
  assign rdata_o   = rdata_oe_o ? ram_rdata : '0;
  assign fsm_state = state;

endmodule

// File: tb/tb_bus_mem_responder.sv
// Directed bench for bus_mem_responder: a vector table of bus accesses with
// hand-derived responses, then hand-written reset corner sequences.
module tb_bus_mem_responder;
  import bus_mem_responder_pkg::*;

  localparam int OP_RD   = 1;
  localparam int OP_WR   = 2;
  localparam int OP_BOTH = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        oe;
  logic        we;
  logic [7:0]  rdata_o;
  logic        rdata_oe_o;
  logic        ready_o;
  logic        err_o;
  logic [15:0] rd_count_o;
  logic [15:0] wr_count_o;
  logic [7:0]  err_count_o;
  state_t      fsm_state;

  bus_mem_responder dut (
    .clk         (clk),
    .reset       (reset),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .oe_i        (oe),
    .we_i        (we),
    .rdata_o     (rdata_o),
    .rdata_oe_o  (rdata_oe_o),
    .ready_o     (ready_o),
    .err_o       (err_o),
    .rd_count_o  (rd_count_o),
    .wr_count_o  (wr_count_o),
    .err_count_o (err_count_o),
    .fsm_state   (fsm_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  typedef struct {
    int          op;
    logic [15:0] addr;
    logic [7:0]  wdata;
    int          hold;       // negedges the strobe stays high after the request
    bit          exp_err;
    logic [7:0]  exp_rdata;
    bit          exp_wait;   // FSM expected to pass through WAIT_REL
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] exp_q[$];

  int n_vec  = 0;
  int n_chk  = 0;
  int n_fail = 0;
  int exp_rd = 0;
  int exp_wr = 0;
  int exp_ec = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input int op, input logic [15:0] a, input logic [7:0] d, input int hold,
                     input bit e, input logic [7:0] r, input bit w);
    vec_t v;
    v.op = op; v.addr = a; v.wdata = d; v.hold = hold;
    v.exp_err = e; v.exp_rdata = r; v.exp_wait = w;
    vecs.push_back(v);
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, "_rd_count"},  32'(rd_count_o),  exp_rd);
    chk({tag, "_wr_count"},  32'(wr_count_o),  exp_wr);
    chk({tag, "_err_count"}, 32'(err_count_o), exp_ec);
  endtask

  // Driver + monitor for one bus access, sampled on negedges.
  task automatic run_access(input vec_t v);
    bit is_rd_ok;
    bit saw_wait = 1'b0;
    int r_cnt = 0;
    int e_cnt = 0;
    int r_cyc = -1;
    int e_cyc = -1;
    int oe_cnt = 0;
    int bad = 0;
    @(negedge clk);
    addr  = v.addr;
    wdata = v.wdata;
    oe    = (v.op == OP_RD) || (v.op == OP_BOTH);
    we    = (v.op == OP_WR) || (v.op == OP_BOTH);
    is_rd_ok = (v.op == OP_RD) && !v.exp_err;
    if (is_rd_ok) exp_q.push_back(v.exp_rdata);
    for (int c = 1; c <= v.hold + 4; c++) begin
      @(negedge clk);
      if (ready_o) begin r_cnt++; if (r_cyc < 0) r_cyc = c; end
      if (err_o)   begin e_cnt++; if (e_cyc < 0) e_cyc = c; end
      if (rdata_oe_o) begin
        oe_cnt++;
        if (!ready_o || !is_rd_ok) bad++;
        else if (exp_q.size() > 0) chk("rdata", 32'(rdata_o), 32'(exp_q.pop_front()));
      end else if (rdata_o !== 8'h00) begin
        bad++;
      end
      if (fsm_state == ST_WAIT_REL) saw_wait = 1'b1;
      if (c == v.hold) begin oe = 1'b0; we = 1'b0; end
    end
    chk("ready_pulses", r_cnt, v.exp_err ? 0 : 1);
    if (!v.exp_err) chk("ready_latency", r_cyc, 2);
    chk("err_pulses", e_cnt, v.exp_err ? 1 : 0);
    if (v.exp_err) chk("err_latency", e_cyc, 1);
    chk("oe_cycles", oe_cnt, is_rd_ok ? 1 : 0);
    chk("oe_or_rdata_outside_read_resp", bad, 0);
    chk("wait_rel_seen", 32'(saw_wait), 32'(v.exp_wait));
    chk("back_in_idle", 32'(fsm_state), 32'(ST_IDLE));
    if (exp_q.size() != 0) begin
      chk("read_data_missing", exp_q.size(), 0);
      exp_q.delete();
    end
    if (v.exp_err) exp_ec = (exp_ec < 255) ? exp_ec + 1 : 255;
    else if (v.op == OP_RD) exp_rd = (exp_rd < 65535) ? exp_rd + 1 : 65535;
    else exp_wr = (exp_wr < 65535) ? exp_wr + 1 : 65535;
    chk_counters("vec");
    n_vec++;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"},   32'(ready_o),    0);
    chk({tag, "_err"},     32'(err_o),      0);
    chk({tag, "_rdata_oe"},32'(rdata_oe_o), 0);
    chk({tag, "_rdata"},   32'(rdata_o),    0);
    chk({tag, "_rd_count"},32'(rd_count_o), 0);
    chk({tag, "_wr_count"},32'(wr_count_o), 0);
    chk({tag, "_err_count"},32'(err_count_o),0);
    chk({tag, "_state"},   32'(fsm_state),  32'(ST_IDLE));
  endtask

  initial begin
    vec_t v;
    // Vector table: write/read pair, full sweep, errors, held strobe, boundaries.
    add(OP_WR,   16'h0002, 8'h25, 2, 0, 8'h00, 0);
    add(OP_RD,   16'h0002, 8'h00, 1, 0, 8'h25, 0);
    for (int i = 0; i < 256; i++) add(OP_WR, 16'(i), 8'(255 - i), 1, 0, 8'h00, 0);
    for (int i = 0; i < 256; i++) add(OP_RD, 16'(i), 8'h00, 1, 0, 8'(255 - i), 0);
    add(OP_RD,   16'h8000, 8'h00, 1, 1, 8'h00, 0);
    add(OP_WR,   16'h8002, 8'h77, 1, 1, 8'h00, 0);
    add(OP_RD,   16'h0100, 8'h00, 1, 1, 8'h00, 0);
    add(OP_RD,   16'h0002, 8'h00, 1, 0, 8'hFD, 0);   // untouched by 0x8002 write
    add(OP_BOTH, 16'h0010, 8'hAA, 1, 1, 8'h00, 0);
    add(OP_RD,   16'h0010, 8'h00, 1, 0, 8'hEF, 0);   // untouched by dual strobe
    add(OP_RD,   16'h0003, 8'h00, 10, 0, 8'hFC, 1);  // held strobe: one access
    add(OP_RD,   16'h0003, 8'h00, 1, 0, 8'hFC, 0);   // accepted again after release
    add(OP_WR,   16'hFFFF, 8'h00, 3, 1, 8'h00, 1);   // error with held strobe
    add(OP_WR,   16'h00FF, 8'h5A, 1, 0, 8'h00, 0);   // last legal word
    add(OP_RD,   16'h00FF, 8'h00, 1, 0, 8'h5A, 0);
    add(OP_WR,   16'h0005, 8'h11, 1, 0, 8'h00, 0);   // preload for reset test

    reset = 1'b1; addr = '0; wdata = '0; oe = 1'b0; we = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("in_reset");
    reset = 1'b0;
    @(negedge clk);
    chk_all_zero("after_reset");

    for (int k = 0; k < vecs.size(); k++) begin
      v = vecs[k];
      run_access(v);
    end

    // Reset during ACCESS: the pending write must not land.
    @(negedge clk);
    addr = 16'h0005; wdata = 8'h8F; we = 1'b1;
    @(posedge clk);
    #2;
    chk("mid_write_in_access", 32'(fsm_state), 32'(ST_ACCESS));
    reset = 1'b1;
    #1;
    chk_all_zero("reset_mid_write");
    @(negedge clk);
    we = 1'b0;
    @(negedge clk);
    chk_all_zero("reset_mid_write_held");
    reset = 1'b0;
    exp_rd = 0; exp_wr = 0; exp_ec = 0;
    n_vec++;
    v.op = OP_RD; v.addr = 16'h0005; v.wdata = 8'h00; v.hold = 1;
    v.exp_err = 0; v.exp_rdata = 8'h11; v.exp_wait = 0;
    run_access(v);

    // Reset during a read response: ready and drive enable drop at once.
    @(negedge clk);
    addr = 16'h0005; oe = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("resp_ready",    32'(ready_o),    1);
    chk("resp_rdata_oe", 32'(rdata_oe_o), 1);
    chk("resp_rdata",    32'(rdata_o),    32'h11);
    reset = 1'b1;
    #1;
    chk_all_zero("reset_in_resp");
    @(negedge clk);
    oe = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    exp_rd = 0; exp_wr = 0; exp_ec = 0;
    n_vec++;

    // RAM survives reset; responder recovers normally.
    v.op = OP_RD; v.addr = 16'h0010; v.wdata = 8'h00; v.hold = 1;
    v.exp_err = 0; v.exp_rdata = 8'hEF; v.exp_wait = 0;
    run_access(v);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_mem_responder.md
Name: bus_mem_responder

Overview:
- Memory-side responder for the CPU system bus.
- Serves the CPU (or a bench master) that drives address, write data and the OE/WE strobes.
- Decodes the 16-bit address into a local RAM window and performs one registered read or write per strobe assertion.
- Returns a ready/error handshake, a tri-state drive enable for the shared data bus, and saturating access statistics for debug.

Parameters:
DATA_WIDTH, 8, data bus width in bits
ADDR_WIDTH, 16, address bus width in bits
MEM_DEPTH, 256, number of RAM words; legal offsets 0..MEM_DEPTH-1
BASE_ADDR, 16'h0000, first address of the RAM window

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  asynchronous, active-high reset
addr_i  in  ADDR_WIDTH  bus address
wdata_i  in  DATA_WIDTH  bus write data
oe_i  in  1  read strobe (level; one access per assertion)
we_i  in  1  write strobe (level; one access per assertion)
rdata_o  out  DATA_WIDTH  read data, valid while ready_o=1 for a read
rdata_oe_o  out  1  drive enable for data bus tri-state; high only during a read response
ready_o  out  1  one-cycle completion pulse
err_o  out  1  one-cycle error pulse
rd_count_o  out  16  completed reads, saturating
wr_count_o  out  16  completed writes, saturating
err_count_o  out  8  errored requests, saturating

Behaviour:
- Reset: async, active-high. Forces state=IDLE and these outputs to zero: rdata_o, rdata_oe_o, ready_o, err_o, all counters. RAM contents are not cleared; they stay preloadable by $readmemh on the array.
- States:
  - IDLE -> ACCESS, ERR or IDLE: at edge N, if oe_i|we_i, latch addr, wdata and kind (rd/wr).
  - ACCESS: performs the RAM operation at edge N+1, then -> RESP.
  - RESP: ready_o=1. For a read, rdata_oe_o=1 and rdata_o holds mem[offset]. At the next edge, go to IDLE if oe_i=we_i=0, else WAIT_REL.
  - ERR: err_o=1 for one cycle, no RAM access. Next edge -> WAIT_REL, or IDLE if strobes are already low.
  - WAIT_REL: holds until oe_i=we_i=0, then -> IDLE. A held strobe never triggers a second access.
- Error conditions, evaluated in IDLE on the latched request:
  - oe_i&we_i both high;
  - addr_i[ADDR_WIDTH-1]=1;
  - (addr_i-BASE_ADDR) >= MEM_DEPTH, or addr_i < BASE_ADDR.
  - On error: rdata_o=0, rdata_oe_o=0.
- Latency: request sampled at edge N. ready_o is high from edge N+1 to N+2. Write data lands in RAM at edge N+1. Read data is registered at edge N+1.
- Offset = addr - BASE_ADDR, truncated to clog2(MEM_DEPTH) bits after the range check.
- Counters: increment on entry to RESP (rd or wr) or ERR. Each saturates at all-ones; no wrap.
- Strobes asserted while in ACCESS/RESP/ERR are ignored. A strobe that rises exactly as state returns to IDLE is sampled normally on the following edge.
- Reset mid-operation:
  - Reset in ACCESS before edge N+1: no write occurs and no ready is issued.
  - Reset in RESP: ready_o/rdata_oe_o drop immediately (async).
- rdata_oe_o must never be high outside RESP-of-read, so the block never contends with a master driving the bus.

Decomposition:
- Shared package/include: DATA_WIDTH, MEMORY_DEPTH and ADDR_WIDTH macros from the common includes file; state encoding constants (IDLE, ACCESS, RESP, ERR, WAIT_REL); counter saturation widths.
- One sub-module, ram_array: synchronous single-port RAM with write enable and registered read, DEPTH/WIDTH parameters, no reset on the array.
- FSM, decode and counters stay in bus_mem_responder.

Test Plan:
- Write then read:
  - Stimulus: reset pulse; write addr=16'h0002 data=8'h25 (we_i held 2 cycles); then read addr=16'h0002.
  - Expected: ready_o pulse at N+1 on each; read gives rdata_o=8'h25 with rdata_oe_o=1 for exactly 1 cycle; wr_count_o=1, rd_count_o=1.
- Sweep:
  - Stimulus: write 255-i to addr i for i=0..255, then read all back.
  - Expected: every read returns 255-i; rd_count_o=256, wr_count_o=256; err_count_o=0.
- Out of range:
  - Stimulus: read 16'h8000, write 16'h8002, read 16'h0100 (BASE_ADDR=0, MEM_DEPTH=256).
  - Expected: err_o pulse each time, no ready_o, rdata_oe_o stays 0, RAM unchanged, err_count_o=3.
- Simultaneous strobes:
  - Stimulus: oe_i=we_i=1 at addr 16'h0010 with data 8'hAA.
  - Expected: err_o pulse; mem[16] unchanged; neither rd nor wr counter increments.
- Held strobe:
  - Stimulus: oe_i held high 10 cycles at addr 16'h0003.
  - Expected: exactly one ready_o pulse and rd_count_o +1; FSM sits in WAIT_REL until oe_i falls, then accepts a new read on the next assertion.
- Reset mid-write:
  - Stimulus: we_i at addr 16'h0005 data 8'h8F; assert reset during ACCESS (before edge N+1), with mem[5] preloaded 8'h11.
  - Expected: mem[5] stays 8'h11; all outputs 0 immediately; counters 0.
